// File: rtl/systolic_pe_param.sv
// ============================================================================
// systolic_pe_param : systolic PE, run-time coefficients, shift-add multiply,
//                     row accumulation. Optional SYSTOLIC_PE_SAT_EN saturates.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_pe_param #(
  parameter int WORDLENGTH  = 16,
  parameter int ROW_LEN     = 8,
  parameter int FRAC_BITS   = 15,
  parameter int START_INDEX = 0
) (
  input  logic                       clk30x,
  input  logic                       reset,
  input  logic                       row_clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORDLENGTH-1:0]      inputword,
  input  logic                       coef_we,
  input  logic [$clog2(ROW_LEN)-1:0] coef_addr,
  input  logic [WORDLENGTH-1:0]      coef_data,
  output logic                       out_valid,
  output logic [WORDLENGTH-1:0]      outputword,
  output logic [$clog2(ROW_LEN)-1:0] phase
);

  localparam int AW   = $clog2(ROW_LEN);
  localparam int CW   = $clog2(WORDLENGTH + 1);
  localparam int ACCW = WORDLENGTH + AW + 1;
  localparam int PW   = 2 * WORDLENGTH;

  localparam logic [AW-1:0] START = AW'(START_INDEX);
  localparam logic [AW-1:0] LAST  = AW'(ROW_LEN - 1);
  localparam logic [AW:0]   ROWS  = (AW + 1)'(ROW_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORDLENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WORDLENGTH-1:0]  coef [ROW_LEN];
  logic [PW-1:0]          mcand;
  logic [WORDLENGTH-1:0]  mplier;
  logic [PW-1:0]          prod;
  logic                   neg;
  logic [CW-1:0]          bit_cnt;
  logic signed [ACCW-1:0] acc;

  logic                   accept;
  logic                   mult_done;
  logic [WORDLENGTH-1:0]  coef_sel;
  logic [WORDLENGTH-1:0]  a_mag;
  logic [WORDLENGTH-1:0]  c_mag;
  logic signed [PW-1:0]   prod_s;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] sum;
  logic [WORDLENGTH-1:0]  reduced;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign mult_done = (state == MULT) && (bit_cnt == LAST_BIT);
  assign coef_sel  = coef[phase];

  // Magnitudes are unsigned, so the most negative value maps to 2^(W-1) exactly.
  assign a_mag = inputword[WORDLENGTH-1] ? -inputword : inputword;
  assign c_mag = coef_sel[WORDLENGTH-1]  ? -coef_sel  : coef_sel;

  assign prod_s = neg ? -$signed(prod) : $signed(prod);
  assign term   = ACCW'(prod_s >>> FRAC_BITS);
  assign sum    = ((phase == '0) ? '0 : acc) + term;

`ifdef SYSTOLIC_PE_SAT_EN
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-WORDLENGTH+1){1'b0}}, {(WORDLENGTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-WORDLENGTH+1){1'b1}}, {(WORDLENGTH-1){1'b0}}};

  always_comb begin
    reduced = WORDLENGTH'(sum);
    if (sum > SMAX)
      reduced = {1'b0, {(WORDLENGTH-1){1'b1}}};
    else if (sum < SMIN)
      reduced = {1'b1, {(WORDLENGTH-1){1'b0}}};
  end
`else
  always_comb begin
    reduced = WORDLENGTH'(sum);
  end
`endif

  always_ff @(posedge clk30x) begin
    if (reset || row_clr)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = MULT;
      MULT:    if (mult_done) state_nx = ACC;
      ACC:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk30x) begin
    if (reset) begin
      for (int i = 0; i < ROW_LEN; i++) coef[i] <= '0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      neg        <= 1'b0;
      bit_cnt    <= '0;
      acc        <= '0;
      phase      <= START;
      outputword <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // Same-cycle accept reads the old coefficient through coef_sel.
      if (coef_we && ({1'b0, coef_addr} < ROWS))
        coef[coef_addr] <= coef_data;

      if (row_clr) begin
        acc   <= '0;
        phase <= START;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              mcand   <= {{WORDLENGTH{1'b0}}, a_mag};
              mplier  <= c_mag;
              neg     <= inputword[WORDLENGTH-1] ^ coef_sel[WORDLENGTH-1];
              prod    <= '0;
              bit_cnt <= '0;
            end
          end
          MULT: begin
            prod    <= prod + (mplier[0] ? mcand : '0);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            bit_cnt <= bit_cnt + CW'(1);
          end
          ACC: begin
            if (phase == LAST) begin
              outputword <= reduced;
              out_valid  <= 1'b1;
              acc        <= '0;
              phase      <= '0;
            end else begin
              acc   <= sum;
              phase <= phase + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_pe_param.sv
// tb_systolic_pe_param : scoreboard bench for systolic_pe_param
// (default instance plus a START_INDEX=5 instance sharing the stimulus).
`timescale 1ns/1ps
`default_nettype none

module tb_systolic_pe_param;
  localparam int W  = 16;
  localparam int RL = 8;
  localparam int AW = 3;

  logic          clk30x    = 1'b0;
  logic          reset     = 1'b1;
  logic          row_clr   = 1'b0;
  logic          in_valid  = 1'b0;
  logic          coef_we   = 1'b0;
  logic [W-1:0]  inputword = '0;
  logic [W-1:0]  coef_data = '0;
  logic [AW-1:0] coef_addr = '0;
  logic          in_ready, out_valid, in_ready5, out_valid5;
  logic [W-1:0]  outputword, outputword5;
  logic [AW-1:0] phase, phase5;

  systolic_pe_param #(.WORDLENGTH(W), .ROW_LEN(RL), .FRAC_BITS(15), .START_INDEX(0)) dut (
    .clk30x(clk30x), .reset(reset), .row_clr(row_clr), .in_valid(in_valid),
    .in_ready(in_ready), .inputword(inputword), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid),
    .outputword(outputword), .phase(phase));

  systolic_pe_param #(.WORDLENGTH(W), .ROW_LEN(RL), .FRAC_BITS(15), .START_INDEX(5)) dut5 (
    .clk30x(clk30x), .reset(reset), .row_clr(row_clr), .in_valid(in_valid),
    .in_ready(in_ready5), .inputword(inputword), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid5),
    .outputword(outputword5), .phase(phase5));

  always #5 clk30x = ~clk30x;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mc [RL];
  int           mphase;
  longint       macc;
  logic [W-1:0] q [$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] last_out = '0;
  logic         ov5_seen;
  logic [W-1:0] ow5_seen;

  // Scoreboard consumer: every out_valid pulse must match the oldest expected row.
  always @(negedge clk30x) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid outputword=%h, no row result pending", outputword);
      end else begin
        mon_exp = q.pop_front();
        last_out = mon_exp;
        if (outputword !== mon_exp) begin
          errors++;
          $display("FAIL row_result outputword=%h expected %h", outputword, mon_exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] reduce_m(input longint v);
`ifdef SYSTOLIC_PE_SAT_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return W'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RL; i++) mc[i] = '0;
    mphase = 0;
    macc = 0;
    q.delete();
  endtask

  task automatic model_step(input logic [W-1:0] s, output bit last);
    longint p;
    p = longint'($signed(s)) * longint'($signed(mc[mphase]));
    p = p >>> 15;
    if (mphase == 0) macc = p;
    else macc = macc + p;
    if (mphase == RL - 1) begin
      q.push_back(reduce_m(macc));
      macc = 0;
      mphase = 0;
      last = 1'b1;
    end else begin
      mphase++;
      last = 1'b0;
    end
  endtask

  task automatic write_coef(input int a, input logic [W-1:0] d);
    @(negedge clk30x);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_data = d;
    @(posedge clk30x);
    #1;
    coef_we = 1'b0;
    mc[a] = d;
  endtask

  task automatic set_all(input logic [W-1:0] d);
    for (int i = 0; i < RL; i++) write_coef(i, d);
  endtask

  task automatic set_random();
    for (int i = 0; i < RL; i++) write_coef(i, W'($urandom));
  endtask

  // One sample: accept, check busy window, then check the cycle where the PE is ready again.
  task automatic send(input logic [W-1:0] s, input bit hold, input bit wr, input logic [W-1:0] wdata);
    int guard;
    int wa;
    bit last;
    bit busy_bad;
    guard = 0;
    @(negedge clk30x);
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk30x);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout in_ready=%b after %0d cycles, expected 1", in_ready, guard);
      return;
    end
    inputword = s;
    in_valid = 1'b1;
    wa = mphase;
    if (wr) begin
      coef_we = 1'b1;
      coef_addr = AW'(wa);
      coef_data = wdata;
    end
    @(posedge clk30x);
    model_step(s, last);
    if (wr) mc[wa] = wdata;
    #1;
    if (!hold) in_valid = 1'b0;
    coef_we = 1'b0;
    busy_bad = (in_ready !== 1'b0);
    repeat (16) begin
      @(posedge clk30x);
      #1;
      if (in_ready !== 1'b0) busy_bad = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL busy_in_ready in_ready went high within 17 cycles of accept, expected 0");
    end
    @(posedge clk30x);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_return in_ready=%b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== last) begin
      errors++;
      $display("FAIL out_valid_timing out_valid=%b expected %b", out_valid, last);
    end
    checks++;
    if (phase !== AW'(mphase)) begin
      errors++;
      $display("FAIL phase phase=%0d expected %0d", phase, mphase);
    end
    ov5_seen = out_valid5;
    ow5_seen = outputword5;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk30x);
    #1;
    reset = 1'b0;
    checks++;
    if (outputword !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1 || phase !== 3'd0) begin
      errors++;
      $display("FAIL reset_state ow=%h ov=%b rdy=%b ph=%0d expected 0000 0 1 0",
               outputword, out_valid, in_ready, phase);
    end
    checks++;
    if (phase5 !== 3'd5) begin
      errors++;
      $display("FAIL reset_phase_start5 phase=%0d expected 5", phase5);
    end
  endtask

  task automatic test_basic();
    write_coef(0, 16'h4000);
    for (int i = 1; i < RL; i++) write_coef(i, 16'h0000);
    send(16'h1000, 1'b0, 1'b0, '0);
    for (int i = 1; i < RL; i++) send(16'h7FFF, 1'b0, 1'b0, '0);
    checks++;
    if (outputword !== 16'h0800) begin
      errors++;
      $display("FAIL basic_row outputword=%h expected 0800", outputword);
    end
  endtask

  task automatic test_timing_hold();
    set_random();
    for (int i = 0; i < RL; i++) send(W'($urandom), 1'b1, 1'b0, '0);
  endtask

  task automatic test_signs();
    set_all(16'hC000);
    for (int i = 0; i < RL; i++) send(16'h2000, 1'b0, 1'b0, '0);
    write_coef(0, 16'h4000);
    for (int i = 1; i < RL; i++) write_coef(i, 16'h0000);
    send(16'hFFFF, 1'b0, 1'b0, '0);
    for (int i = 1; i < RL; i++) send(W'($urandom), 1'b0, 1'b0, '0);
    checks++;
    if (outputword !== 16'hFFFF) begin
      errors++;
      $display("FAIL floor_negative outputword=%h expected ffff", outputword);
    end
    send(16'h0001, 1'b0, 1'b0, '0);
    for (int i = 1; i < RL; i++) send(W'($urandom), 1'b0, 1'b0, '0);
    checks++;
    if (outputword !== 16'h0000) begin
      errors++;
      $display("FAIL floor_positive outputword=%h expected 0000", outputword);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_ovf;
`ifdef SYSTOLIC_PE_SAT_EN
    exp_ovf = 16'h7FFF;
`else
    exp_ovf = 16'h8000;
`endif
    set_all(16'h4000);
    for (int i = 0; i < RL; i++) send(16'h2000, 1'b0, 1'b0, '0);
    checks++;
    if (outputword !== exp_ovf) begin
      errors++;
      $display("FAIL overflow_row outputword=%h expected %h", outputword, exp_ovf);
    end
    set_all(16'h8000);
    for (int i = 0; i < RL; i++) send(16'h8000, 1'b0, 1'b0, '0);
  endtask

  task automatic test_coef_collision();
    set_random();
    for (int i = 0; i < RL; i++)
      send(W'($urandom), 1'b0, (i == 2 || i == 5), W'($urandom));
    for (int i = 0; i < RL; i++) send(W'($urandom), 1'b0, 1'b0, '0);
  endtask

  task automatic test_row_clr();
    set_random();
    for (int i = 0; i < 3; i++) send(W'($urandom), 1'b0, 1'b0, '0);
    @(negedge clk30x);
    inputword = W'($urandom);
    in_valid = 1'b1;
    @(posedge clk30x);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk30x);
    @(negedge clk30x);
    row_clr = 1'b1;
    @(posedge clk30x);
    #1;
    row_clr = 1'b0;
    mphase = 0;
    macc = 0;
    checks++;
    if (phase !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL row_clr_state ph=%0d ov=%b rdy=%b expected 0 0 1", phase, out_valid, in_ready);
    end
    checks++;
    if (outputword !== last_out || phase5 !== 3'd5) begin
      errors++;
      $display("FAIL row_clr_hold ow=%h ph5=%0d expected %h 5", outputword, phase5, last_out);
    end
    repeat (25) @(posedge clk30x);
    for (int i = 0; i < RL; i++) send(W'($urandom), 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    set_random();
    for (int i = 0; i < 2; i++) send(W'($urandom), 1'b0, 1'b0, '0);
    @(negedge clk30x);
    inputword = W'($urandom);
    in_valid = 1'b1;
    @(posedge clk30x);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk30x);
    @(negedge clk30x);
    reset = 1'b1;
    @(posedge clk30x);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (outputword !== 16'h0000 || out_valid !== 1'b0 || phase !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_state ow=%h ov=%b ph=%0d rdy=%b expected 0000 0 0 1",
               outputword, out_valid, phase, in_ready);
    end
    checks++;
    if (phase5 !== 3'd5 || outputword5 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_start5 ph5=%0d ow5=%h expected 5 0000", phase5, outputword5);
    end
    for (int i = 0; i < RL; i++) begin
      send(W'($urandom_range(1, 65535)), 1'b0, 1'b0, '0);
      if (i < 2) begin
        checks++;
        if (ov5_seen !== 1'b0) begin
          errors++;
          $display("FAIL start5_early sample=%0d out_valid5=%b expected 0", i + 1, ov5_seen);
        end
      end else if (i == 2) begin
        checks++;
        if (ov5_seen !== 1'b1 || ow5_seen !== 16'h0000) begin
          errors++;
          $display("FAIL start5_first_row out_valid5=%b ow5=%h expected 1 0000", ov5_seen, ow5_seen);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing_hold();
    test_signs();
    test_overflow();
    test_coef_collision();
    test_row_clr();
    test_reset_mid();
    repeat (30) @(posedge clk30x);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_results %0d rows never emitted, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
